config_streamer: RTL

CONFIG_STREAMER -- requirements
Module: config_streamer

---
 rtl/config_streamer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/config_streamer.sv
// Byte-stream configuration loader: parses a framed host stream into
// address/data write strobes broadcast to all tiles, with XOR checksum check.
module config_streamer #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    ADDR,
    DATA,
    WRITE,
    GAP,
    CSUM,
    FIN
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [31:0] addr_sh_q, addr_sh_d;
  logic [31:0] data_sh_q, data_sh_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  xor_q, xor_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] cfg_addr_q, cfg_addr_d;
  logic [31:0] cfg_data_q, cfg_data_d;
  logic        err_q, err_d;

  logic        accepting;
  logic        take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      byte_idx_q <= '0;
      xor_q      <= '0;
      gap_cnt_q  <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      byte_idx_q <= byte_idx_d;
      xor_q      <= xor_d;
      gap_cnt_q  <= gap_cnt_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      err_q      <= err_d;
    end
  end

  // Gating ready with the reset pin keeps it low during reset yet high in
  // the very first cycle after release, since IDLE is already the state.
  always_comb begin
    accepting = (state_q == IDLE) || (state_q == CNT_LO) || (state_q == ADDR) ||
                (state_q == DATA) || (state_q == CSUM);
    in_ready  = accepting && reset;
    take      = in_ready && in_valid;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    byte_idx_d = byte_idx_q;
    xor_d      = xor_q;
    gap_cnt_d  = gap_cnt_q;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (take) begin
          count_d    = {in_byte, 8'h00};
          xor_d      = 8'h00;
          byte_idx_d = 2'd0;
          err_d      = 1'b0;
          state_d    = CNT_LO;
        end
      end
      CNT_LO: begin
        if (take) begin
          count_d = {count_q[15:8], in_byte};
          state_d = ({count_q[15:8], in_byte} != 16'h0000) ? ADDR : CSUM;
        end
      end
      ADDR: begin
        if (take) begin
          addr_sh_d  = {addr_sh_q[23:0], in_byte};
          xor_d      = xor_q ^ in_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (take) begin
          data_sh_d  = {data_sh_q[23:0], in_byte};
          xor_d      = xor_q ^ in_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          // Output registers only move here, so they stay stable while
          // the following frame is being assembled.
          if (byte_idx_q == 2'd3) begin
            cfg_addr_d = addr_sh_q;
            cfg_data_d = {data_sh_q[23:0], in_byte};
            state_d    = WRITE;
          end
        end
      end
      WRITE: begin
        count_d   = count_q - 16'd1;
        gap_cnt_d = 4'd0;
        state_d   = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = (count_q != 16'h0000) ? ADDR : CSUM;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      CSUM: begin
        if (take) begin
          if (in_byte != xor_q) begin
            err_d = 1'b1;
          end
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    config_addr = cfg_addr_q;
    config_data = cfg_data_q;
    config_en   = (state_q == WRITE);
    busy        = (state_q != IDLE);
    done        = (state_q == FIN);
    err         = err_q;
  end

endmodule
